jpeg_bit_packer: RTL and testbench

//  Packs the variable-length Huffman codes (code, length) from the per-component

---
 rtl/jpeg_pkg.sv | 20 ++
 rtl/jpeg_code_mask.sv | 21 ++
 rtl/jpeg_bit_packer.sv | 180 ++++++++++++++++++
 tb/tb_jpeg_bit_packer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG entropy-coded-segment bit packer:
// packer state encoding, marker/stuff byte values, maximum code length.
package jpeg_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STUFF = 2'd1,
        ST_FLUSH = 2'd2
    } pack_state_e;

    localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
    localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
    localparam int         MAX_LEN            = 16;

    // Ones filling the low (8-n) bits of a byte holding n valid bits.
    function automatic logic [7:0] pad_ones(input logic [2:0] n);
        return 8'hFF >> n;
    endfunction

endpackage

// File: rtl/jpeg_code_mask.sv
// Clamps a Huffman code length to MAX_LEN and clears code bits above it.
// Ports: i_code/i_length raw input, o_code masked code, o_length clamped length.
module jpeg_code_mask #(
    parameter int MAX_LEN = jpeg_pkg::MAX_LEN
) (
    input  logic [MAX_LEN-1:0] i_code,
    input  logic [4:0]         i_length,
    output logic [MAX_LEN-1:0] o_code,
    output logic [4:0]         o_length
);

    assign o_length = (i_length > 5'(MAX_LEN)) ? 5'(MAX_LEN) : i_length;

    always_comb begin
        o_code = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            o_code[i] = i_code[i] && (i < int'(o_length));
        end
    end

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs (code, length) pairs MSB-first into bytes with 0xFF/0x00 stuffing
// and 1-bit padding on flush.
// Ports: clock/reset (async high), in_* code stream (valid/ready),
// flush pulse, out_* byte stream (valid/ready), flush_done pulse,
// bit_count = bits held in the accumulator (including the byte on offer).
module jpeg_bit_packer #(
    parameter int MAX_LEN  = jpeg_pkg::MAX_LEN,
    parameter int ACC_W    = 32,
    parameter bit STUFF_EN = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_LEN-1:0] in_code,
    input  logic [4:0]         in_length,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               flush_done,
    output logic [5:0]         bit_count
);

    import jpeg_pkg::*;

    pack_state_e        r_state;
    pack_state_e        r_ret;
    logic [ACC_W-1:0]   r_acc;
    logic [5:0]         r_cnt;
    logic               r_out_valid;
    logic [7:0]         r_out_byte;
    logic               r_flush_done;

    pack_state_e        w_state_nxt;
    pack_state_e        w_ret_nxt;
    logic [ACC_W-1:0]   w_acc_sh;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [5:0]         w_cnt_sh;
    logic [5:0]         w_cnt_nxt;
    logic [MAX_LEN-1:0] w_code;
    logic [4:0]         w_len;
    logic [6:0]         w_sh;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_stuff_trig;
    logic               w_ov_nxt;
    logic [7:0]         w_ob_nxt;
    logic               w_fd_nxt;

    jpeg_code_mask #(
        .MAX_LEN (MAX_LEN)
    ) u_mask (
        .i_code   (in_code),
        .i_length (in_length),
        .o_code   (w_code),
        .o_length (w_len)
    );

    assign in_ready   = (r_state == ST_RUN) &&
                        (r_cnt <= 6'(ACC_W - MAX_LEN - 1));
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // A data or pad byte of 0xFF leaving the packer needs a 0x00 behind it.
    assign w_stuff_trig = STUFF_EN && w_out_fire &&
                          (r_state != ST_STUFF) &&
                          (r_out_byte == JPEG_MARKER_PREFIX);

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_acc_sh    = r_acc;
        w_cnt_sh    = r_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (w_out_fire) begin
                    w_acc_sh = r_acc << 8;
                    w_cnt_sh = r_cnt - 6'd8;
                end
                if (w_stuff_trig) begin
                    w_state_nxt = ST_STUFF;
                    w_ret_nxt   = flush ? ST_FLUSH : ST_RUN;
                end else if (flush) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_STUFF: begin
                if (w_out_fire) begin
                    w_state_nxt = r_ret;
                end
            end
            ST_FLUSH: begin
                if (w_out_fire) begin
                    // A partial byte went out padded: nothing is left behind.
                    if (r_cnt >= 6'd8) begin
                        w_acc_sh = r_acc << 8;
                        w_cnt_sh = r_cnt - 6'd8;
                    end else begin
                        w_acc_sh = '0;
                        w_cnt_sh = '0;
                    end
                    if (w_stuff_trig) begin
                        w_state_nxt = ST_STUFF;
                        w_ret_nxt   = ST_FLUSH;
                    end
                end else if (r_cnt == 6'd0) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // New code lands directly below the bits still held after any emit.
    assign w_sh = 7'(ACC_W) - {1'b0, w_cnt_sh} - {2'b0, w_len};

    always_comb begin
        w_acc_nxt = w_acc_sh;
        w_cnt_nxt = w_cnt_sh;
        if (w_in_fire) begin
            w_acc_nxt = w_acc_sh |
                        ({{(ACC_W-MAX_LEN){1'b0}}, w_code} << w_sh);
            w_cnt_nxt = w_cnt_sh + {1'b0, w_len};
        end
    end

    // Outputs are registered from the next state so they hold steady
    // while the downstream stalls.
    always_comb begin
        w_ov_nxt = 1'b0;
        w_ob_nxt = w_acc_nxt[ACC_W-1 -: 8];
        w_fd_nxt = 1'b0;
        unique case (w_state_nxt)
            ST_STUFF: begin
                w_ov_nxt = 1'b1;
                w_ob_nxt = JPEG_STUFF_BYTE;
            end
            ST_FLUSH: begin
                w_ov_nxt = (w_cnt_nxt != 6'd0);
                w_fd_nxt = (w_cnt_nxt == 6'd0);
                if (w_cnt_nxt < 6'd8) begin
                    w_ob_nxt = w_acc_nxt[ACC_W-1 -: 8] |
                               pad_ones(w_cnt_nxt[2:0]);
                end
            end
            default: begin
                w_ov_nxt = (w_cnt_nxt >= 6'd8);
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_ret        <= ST_RUN;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_byte   <= 8'h00;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ret        <= w_ret_nxt;
            r_acc        <= w_acc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_out_valid  <= w_ov_nxt;
            r_out_byte   <= w_ob_nxt;
            r_flush_done <= w_fd_nxt;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_byte   = r_out_byte;
    assign flush_done = r_flush_done;
    assign bit_count  = r_cnt;

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Directed and randomized bench for jpeg_bit_packer against a bit-queue
// reference model of concatenation, stuffing and flush padding.
module tb_jpeg_bit_packer;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] in_code   = '0;
    logic [4:0]  in_length = '0;
    logic        flush     = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        flush_done;
    logic [5:0]  bit_count;

    int vectors     = 0;
    int miscompares = 0;

    bit         mbits[$];
    logic [8:0] expq[$];
    logic [7:0] got[$];

    bit         rnd        = 1'b0;
    bit         acc_seen   = 1'b0;
    bit         done_seen  = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte  = '0;

    jpeg_bit_packer dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_length  (in_length),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .flush_done (flush_done),
        .bit_count  (bit_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_byte();
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b = {b[6:0], mbits.pop_front()};
        expq.push_back({1'b0, b});
        if (b == 8'hFF) expq.push_back(9'h000);
    endtask

    task automatic model_code(input logic [15:0] c, input int len);
        int l;
        l = (len > 16) ? 16 : len;
        for (int i = l - 1; i >= 0; i--) mbits.push_back(c[i]);
        while (mbits.size() >= 8) model_byte();
    endtask

    task automatic model_flush();
        if (mbits.size() > 0) begin
            while (mbits.size() < 8) mbits.push_back(1'b1);
            model_byte();
        end
    endtask

    task automatic cycle();
        logic [8:0] e;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clock);
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_byte", out_byte, prev_byte);
        end
        if (out_valid && out_ready) begin
            got.push_back(out_byte);
            e = (expq.size() > 0) ? expq.pop_front() : 9'h100;
            chk("byte", {24'b0, out_byte}, {23'b0, e});
        end
        if (in_valid && in_ready) begin
            acc_seen = 1'b1;
            model_code(in_code, int'(in_length));
        end
        if (flush) model_flush();
        if (flush_done) done_seen = 1'b1;
        prev_stall = out_valid && !out_ready;
        prev_byte  = out_byte;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] c, input logic [4:0] len);
        in_code   = c;
        in_length = len;
        in_valid  = 1'b1;
        acc_seen  = 1'b0;
        for (int k = 0; k < 200 && !acc_seen; k++) cycle();
        chk("accept_timeout", acc_seen, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 300 && expq.size() != 0; k++) cycle();
        chk("drain_timeout", expq.size(), 0);
        chk("bitcnt", bit_count, mbits.size());
    endtask

    task automatic do_flush();
        out_ready = 1'b1;
        for (int k = 0; k < 100 && !in_ready; k++) cycle();
        chk("flush_ready_timeout", in_ready, 1);
        done_seen = 1'b0;
        flush     = 1'b1;
        cycle();
        flush = 1'b0;
        for (int k = 0; k < 100 && !done_seen; k++) cycle();
        chk("flush_done_timeout", done_seen, 1);
        chk("flush_drained", expq.size(), 0);
        chk("flush_bitcnt", bit_count, 0);
        chk("flush_pulse", flush_done, 0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // 101 + 11111 -> 0xBF
        got.delete();
        send(16'h0005, 5'd3);
        send(16'h001F, 5'd5);
        drain();
        chk("t1_n", got.size(), 1);
        chk("t1_b0", got[0], 8'hBF);

        // 0xFF is followed by a stuffed 0x00
        got.delete();
        send(16'h00FF, 5'd8);
        cycle();
        chk("t2_stuff_ready", in_ready, 0);
        chk("t2_stuff_valid", out_valid, 1);
        chk("t2_stuff_byte", out_byte, 8'h00);
        drain();
        chk("t2_n", got.size(), 2);
        chk("t2_b0", got[0], 8'hFF);
        chk("t2_b1", got[1], 8'h00);

        // flush padding, including a pad byte that becomes 0xFF
        got.delete();
        send(16'h0000, 5'd1);
        do_flush();
        chk("t3a_n", got.size(), 1);
        chk("t3a_b0", got[0], 8'h7F);
        got.delete();
        send(16'h0001, 5'd1);
        do_flush();
        chk("t3b_n", got.size(), 2);
        chk("t3b_b0", got[0], 8'hFF);
        chk("t3b_b1", got[1], 8'h00);

        // backpressure: in_ready drops above 15 bits, byte held
        got.delete();
        out_ready = 1'b0;
        send(16'h1234, 5'd16);
        in_code   = 16'hABCD;
        in_length = 5'd16;
        in_valid  = 1'b1;
        acc_seen  = 1'b0;
        repeat (10) cycle();
        chk("t4_no_accept", acc_seen, 0);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_bit_count", bit_count, 16);
        chk("t4_held", out_byte, 8'h12);
        out_ready = 1'b1;
        for (int k = 0; k < 50 && !acc_seen; k++) cycle();
        chk("t4_accept", acc_seen, 1);
        in_valid = 1'b0;
        drain();
        chk("t4_n", got.size(), 4);
        chk("t4_b0", got[0], 8'h12);
        chk("t4_b1", got[1], 8'h34);
        chk("t4_b2", got[2], 8'hAB);
        chk("t4_b3", got[3], 8'hCD);

        // length 0 is a no-op, oversized length clamps to 16
        got.delete();
        send(16'hFFFF, 5'd0);
        cycle();
        chk("t5_len0_valid", out_valid, 0);
        chk("t5_len0_count", bit_count, 0);
        send(16'hFFFF, 5'd20);
        drain();
        chk("t5_n", got.size(), 4);
        chk("t5_b0", got[0], 8'hFF);
        chk("t5_b1", got[1], 8'h00);
        chk("t5_b2", got[2], 8'hFF);
        chk("t5_b3", got[3], 8'h00);

        // reset with bits held discards everything
        out_ready = 1'b0;
        send(16'h0ABC, 5'd12);
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_count", bit_count, 12);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_byte", out_byte, 0);
        chk("t6_flush_done", flush_done, 0);
        chk("t6_bit_count", bit_count, 0);
        chk("t6_in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mbits.delete();
        expq.delete();
        got.delete();
        prev_stall = 1'b0;
        out_ready  = 1'b1;
        send(16'h0055, 5'd8);
        drain();
        chk("t6_n", got.size(), 1);
        chk("t6_b0", got[0], 8'h55);

        // random codes, random backpressure, occasional flush
        rnd = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) cycle();
            send(16'($urandom), 5'($urandom_range(0, 20)));
            if ($urandom_range(0, 29) == 0) begin
                rnd = 1'b0;
                do_flush();
                rnd = 1'b1;
            end
        end
        rnd = 1'b0;
        do_flush();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
